// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel switch debouncer.
// The state encoding keeps the accepted level recoverable from the state alone.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_e;

    // Accepted (debounced) level implied by a state: high while ONE or leaving ONE.
    function automatic logic level_of(input db_state_e st);
        return (st == ONE) || (st == WAIT0);
    endfunction

    function automatic bit params_legal(input int n_ch, input int tick_div, input int stable_ticks);
        return (n_ch >= 1) && (n_ch <= 32) && (tick_div >= 2) && (stable_ticks >= 1);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running sample-tick divider shared by all debounce channels.
// m_tick is registered off the terminal count, so it is high while the counter reads 0.
module tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    output logic m_tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    if (TICK_DIV < 2) begin : g_tick_div_check
        $error("tick_gen: TICK_DIV must be at least 2");
    end

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign m_tick = r_tick;

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent switch debouncers sharing one sample tick.
// Each channel: 2-flop synchronizer, 4-state acceptance FSM, registered level and edge pulses.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int TICK_DIV     = 500000,
    parameter int STABLE_TICKS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            m_tick
);

    localparam int SCW = $clog2(STABLE_TICKS + 1);
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(STABLE_TICKS - 1);

    if (!params_legal(N_CH, TICK_DIV, STABLE_TICKS)) begin : g_param_check
        $error("debounce_multi: illegal N_CH / TICK_DIV / STABLE_TICKS");
    end

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic            w_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .m_tick (w_tick)
    );

    assign m_tick = w_tick;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        db_state_e      r_state;
        db_state_e      w_state_next;
        logic [SCW-1:0] r_scnt;
        logic [SCW-1:0] w_scnt_next;
        logic           r_db;
        logic           r_rise;
        logic           r_fall;
        logic           w_s;
        logic           w_db_next;

        assign w_s = r_sync2[gi];

        // A level flip in a WAIT state aborts before the tick is considered.
        always_comb begin
            w_state_next = r_state;
            w_scnt_next  = r_scnt;
            case (r_state)
                ZERO: begin
                    if (w_s) begin
                        w_state_next = WAIT1;
                        w_scnt_next  = '0;
                    end
                end
                WAIT1: begin
                    if (!w_s) begin
                        w_state_next = ZERO;
                    end else if (w_tick) begin
                        if (r_scnt == SCNT_LAST) w_state_next = ONE;
                        else                     w_scnt_next  = r_scnt + 1'b1;
                    end
                end
                ONE: begin
                    if (!w_s) begin
                        w_state_next = WAIT0;
                        w_scnt_next  = '0;
                    end
                end
                WAIT0: begin
                    if (w_s) begin
                        w_state_next = ONE;
                    end else if (w_tick) begin
                        if (r_scnt == SCNT_LAST) w_state_next = ZERO;
                        else                     w_scnt_next  = r_scnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ZERO;
                    w_scnt_next  = '0;
                end
            endcase
        end

        assign w_db_next = level_of(w_state_next);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= ZERO;
                r_scnt  <= '0;
                r_db    <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_scnt  <= w_scnt_next;
                r_db    <= w_db_next;
                r_rise  <= w_db_next & ~r_db;
                r_fall  <= ~w_db_next & r_db;
            end
        end

        assign db[gi]   = r_db;
        assign rise[gi] = r_rise;
        assign fall[gi] = r_fall;
    end

endmodule
